// File: rtl/inst_issuer_pkg.sv
// Shared types and constants for the PE instruction issuer.
package inst_issuer_pkg;

    localparam int unsigned INST_W     = 12;
    localparam int unsigned OP_W       = 3;
    localparam int unsigned REP_W      = 8;
    localparam int unsigned WAIT_BIT   = 11;
    localparam int unsigned OP_MSB     = 10;
    localparam int unsigned OP_LSB     = 8;
    localparam int unsigned REP_MSB    = 7;
    localparam int unsigned REP_LSB    = 0;
    localparam int unsigned PE_LATENCY = 7;

    localparam logic [OP_W-1:0] OP_LOAD   = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD    = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB    = 3'b010;
    localparam logic [OP_W-1:0] OP_MUL    = 3'b100;
    localparam logic [OP_W-1:0] OP_MULADD = 3'b101;
    localparam logic [OP_W-1:0] OP_MULSUB = 3'b110;
    localparam logic [OP_W-1:0] OP_MAX    = 3'b111;

    typedef struct packed {
        logic              wait_en;
        logic [OP_W-1:0]   op;
        logic [REP_W-1:0]  rep;
    } inst_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Split a raw instruction word into its fields.
    function automatic inst_t unpack_inst(input logic [INST_W-1:0] w);
        inst_t r;
        r.wait_en = w[WAIT_BIT];
        r.op      = w[OP_MSB:OP_LSB];
        r.rep     = w[REP_MSB:REP_LSB];
        return r;
    endfunction

endpackage

// File: rtl/inst_issuer_inst_mem.sv
// Small program store: synchronous write, asynchronous read, no reset.
module inst_mem
    import inst_issuer_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  inst_t             i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output inst_t             o_rdata
);

    inst_t r_mem [DEPTH];

    // Program write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_issuer.sv
// Steps through a stored opcode program, issuing to the PE decoder and
// stalling on wait instructions until outstanding results have drained.
module inst_issuer
    import inst_issuer_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned LATENCY = PE_LATENCY,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned OUTS_W = $clog2(LATENCY + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [INST_W-1:0] prog_data,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              start,
    input  logic              dout_v,
    output logic              inst_v,
    output logic [OP_W-1:0]   opcode,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_last;
    logic [REP_W-1:0]  r_repcnt;
    logic              r_wait;
    logic [OUTS_W-1:0] r_outs;
    logic              r_inst_v;
    logic [OP_W-1:0]   r_opcode;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_rd_addr;
    inst_t             w_rd;
    logic              w_prog_we;
    logic              w_start_ok;
    logic [OUTS_W-1:0] w_outs_nxt;

    assign w_pc_inc   = r_pc + ADDR_W'(1);
    // Memory is read at the entry about to be loaded: 0 on start, else pc+1.
    assign w_rd_addr  = (r_state == ST_IDLE) ? '0 : w_pc_inc;
    assign w_prog_we  = prog_we && !r_busy;
    assign w_start_ok = start && !prog_we;

    inst_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_prog_we),
        .i_waddr (prog_addr),
        .i_wdata (unpack_inst(prog_data)),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd)
    );

    // Next outstanding count; a return with nothing outstanding is dropped.
    always_comb begin
        w_outs_nxt = r_outs;
        if (r_inst_v && !dout_v) begin
            w_outs_nxt = r_outs + OUTS_W'(1);
        end else if (!r_inst_v && dout_v && (r_outs != '0)) begin
            w_outs_nxt = r_outs - OUTS_W'(1);
        end
    end

    // Issue FSM; outputs are registered so the state names the cycle they show in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_last   <= '0;
            r_repcnt <= '0;
            r_wait   <= 1'b0;
            r_outs   <= '0;
            r_inst_v <= 1'b0;
            r_opcode <= OP_LOAD;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_outs <= w_outs_nxt;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_inst_v <= 1'b0;
                    r_opcode <= OP_LOAD;
                    if (w_start_ok) begin
                        r_pc     <= '0;
                        r_last   <= last_addr;
                        r_repcnt <= w_rd.rep;
                        r_wait   <= w_rd.wait_en;
                        r_opcode <= w_rd.op;
                        r_inst_v <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_repcnt != '0) begin
                        r_repcnt <= r_repcnt - REP_W'(1);
                        r_inst_v <= 1'b1;
                    end else if (r_wait || (r_pc == r_last)) begin
                        r_inst_v <= 1'b0;
                        r_state  <= ST_DRAIN;
                    end else begin
                        r_pc     <= w_pc_inc;
                        r_repcnt <= w_rd.rep;
                        r_wait   <= w_rd.wait_en;
                        r_opcode <= w_rd.op;
                        r_inst_v <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_inst_v <= 1'b0;
                    if (w_outs_nxt == '0) begin
                        if (r_pc == r_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_pc     <= w_pc_inc;
                            r_repcnt <= w_rd.rep;
                            r_wait   <= w_rd.wait_en;
                            r_opcode <= w_rd.op;
                            r_inst_v <= 1'b1;
                            r_state  <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    r_inst_v <= 1'b0;
                    r_opcode <= OP_LOAD;
                    r_busy   <= 1'b0;
                    r_pc     <= '0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign inst_v = r_inst_v;
    assign opcode = r_opcode;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
